lsu_mem_port: RTL and testbench
===============================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  global enable; when 0, all registers hold.
REQ-005 ex_valid  input  1  pipeline presents a memory op this cycle.
REQ-006 ex_is_store  input  1  1 = store, 0 = load.
REQ-007 ex_funct3  input  3  RV32I width/sign code.
REQ-008 ex_addr  input  32  byte address.
REQ-009 ex_store_data  input  32  store source, low bytes significant.
REQ-010 clear_in  input  1  pipeline flush.
REQ-011 lsu_busy  output  1  op in flight; pipeline holds ex_* while 1.
REQ-012 wb_valid  output  1  one-cycle pulse, load result ready.
REQ-013 wb_data  output  32  extended load result.
REQ-014 read_mem  output  1  read request to memory controller.
REQ-015 write_mem  output  1  write request to memory controller.
REQ-016 mem_addr  output  32  transaction byte address.
REQ-017 mem_data_to_write  output  32  store data.
REQ-018 data_len  output  3  byte count: 1, 2 or 4.
REQ-019 mem_load_done  input  1  controller completion pulse, registered.
REQ-020 mem_ctrl_load_to_mem  input  32  read data, valid with mem_load_done.

Function
REQ-021 States: IDLE, WAIT_LOAD, WAIT_STORE; encoding free.
REQ-022 IDLE, rdy_in=1, ex_valid=1, clear_in=0: latch ex_addr, ex_store_data, ex_funct3; go WAIT_STORE if ex_is_store, else WAIT_LOAD.
REQ-023 data_len from latched funct3[1:0]: 00->1, 01->2, 10->4, 11->4 (illegal codes treated as word).
REQ-024 read_mem = (state==WAIT_LOAD) && !mem_load_done, combinational; write_mem likewise for WAIT_STORE; never both 1.
REQ-025 mem_addr, mem_data_to_write, data_len remain stable from entry into WAIT_* until exit.
REQ-026 WAIT_* with mem_load_done=1: return to IDLE at that edge.
REQ-027 Load completion: wb_data registered as extension of mem_ctrl_load_to_mem: LB sign-extend bit 7, LH bit 15, LBU/LHU zero-extend, LW as-is; funct3 110/111 as LW.
REQ-028 wb_valid=1 exactly in the cycle after load completion, unless discarded per REQ-031; 0 otherwise.
REQ-029 Store completion produces no wb_valid.
REQ-030 lsu_busy = (state != IDLE), combinational.
REQ-031 clear_in=1 during WAIT_LOAD: transaction runs to mem_load_done (controller is never aborted); result discarded, wb_valid stays 0.
REQ-032 clear_in=1 during WAIT_STORE: store completes normally.
REQ-033 clear_in=1 in IDLE: no op accepted that cycle.
REQ-034 mem_load_done in IDLE: ignored.
REQ-035 Back-to-back: new op accepted no earlier than the cycle after return to IDLE, giving read_mem/write_mem at least one low cycle between transactions.
REQ-036 rdy_in=0: state, latches, wb_valid hold; read_mem/write_mem keep their combinational values.
REQ-037 Latency: load issued cycle T completes at T+1+N+1 edges for an N-byte controller; wb_valid one cycle later.

Reset
REQ-038 rst_in=0 asynchronously forces IDLE; wb_valid=0, wb_data=0, latched addr/data/funct3=0; hence read_mem=write_mem=0, lsu_busy=0.
REQ-039 Reset mid-transaction abandons it; no wb_valid after release; memory controller reset together.

Verification
REQ-040 LB from 0x100, controller returns 0x000000F0 -> wb_data=0xFFFFFFF0, one wb_valid pulse, data_len=1.
REQ-041 LHU 0x200, returns 0x0000F00D -> wb_data=0x0000F00D, data_len=2; LH same -> 0xFFFFF00D.
REQ-042 SW 0x300 data 0xDEADBEEF -> write_mem=1, data_len=4, mem_data_to_write stable until done; no wb_valid; lsu_busy drops after done.
REQ-043 LW then SB back-to-back -> read_mem low the cycle of mem_load_done; write_mem rises no earlier than next cycle; never both high.
REQ-044 clear_in pulse mid-LW -> read_mem held to done, wb_valid stays 0, return to IDLE.
REQ-045 rst_in low mid-load -> read_mem, lsu_busy, wb_valid 0 immediately, without clock edge.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store port between the execute stage and a byte-addressed memory controller.
// One op in flight; loads return an extended result on a one-cycle wb_valid pulse.
module lsu_mem_port (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        ex_valid,
   input  logic        ex_is_store,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_store_data,
   input  logic        clear_in,
   output logic        lsu_busy,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic        read_mem,
   output logic        write_mem,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_to_write,
   output logic [2:0]  data_len,
   input  logic        mem_load_done,
   input  logic [31:0] mem_ctrl_load_to_mem
);

   typedef enum logic [1:0] {IDLE, WAIT_LOAD, WAIT_STORE} state_t;

   state_t      state_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [2:0]  f3_q;
   logic        discard_q;
   logic        wb_valid_q;
   logic [31:0] wb_data_q;
   logic [31:0] ld_ext;

   always_comb begin
      ld_ext = mem_ctrl_load_to_mem;
      case (f3_q)
         3'b000:  ld_ext = {{24{mem_ctrl_load_to_mem[7]}},  mem_ctrl_load_to_mem[7:0]};
         3'b001:  ld_ext = {{16{mem_ctrl_load_to_mem[15]}}, mem_ctrl_load_to_mem[15:0]};
         3'b100:  ld_ext = {24'd0, mem_ctrl_load_to_mem[7:0]};
         3'b101:  ld_ext = {16'd0, mem_ctrl_load_to_mem[15:0]};
         default: ld_ext = mem_ctrl_load_to_mem;
      endcase
   end

   // A flush seen at any point of a load marks it for discard; the controller still finishes.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         f3_q       <= '0;
         discard_q  <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
      end else if (rdy_in) begin
         wb_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               discard_q <= 1'b0;
               if (ex_valid && !clear_in) begin
                  addr_q  <= ex_addr;
                  data_q  <= ex_store_data;
                  f3_q    <= ex_funct3;
                  state_q <= ex_is_store ? WAIT_STORE : WAIT_LOAD;
               end
            end
            WAIT_LOAD: begin
               if (clear_in) discard_q <= 1'b1;
               if (mem_load_done) begin
                  state_q <= IDLE;
                  if (!discard_q && !clear_in) begin
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= ld_ext;
                  end
               end
            end
            WAIT_STORE: begin
               if (mem_load_done) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lsu_busy          = (state_q != IDLE);
   assign read_mem          = (state_q == WAIT_LOAD)  && !mem_load_done;
   assign write_mem         = (state_q == WAIT_STORE) && !mem_load_done;
   assign mem_addr          = addr_q;
   assign mem_data_to_write = data_q;
   assign data_len          = (f3_q[1:0] == 2'b00) ? 3'd1 : (f3_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
   assign wb_valid          = wb_valid_q;
   assign wb_data           = wb_data_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: behavioural memory controller plus a wb_data scoreboard.
module tb_lsu_mem_port;

   localparam int LAT = 2;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        ex_valid = 1'b0;
   logic        ex_is_store = 1'b0;
   logic [2:0]  ex_funct3 = '0;
   logic [31:0] ex_addr = '0;
   logic [31:0] ex_store_data = '0;
   logic        clear_in = 1'b0;
   logic        lsu_busy, wb_valid, read_mem, write_mem;
   logic [31:0] wb_data, mem_addr, mem_data_to_write;
   logic [2:0]  data_len;
   logic        mem_load_done;
   logic [31:0] mem_ctrl_load_to_mem;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mem_rdata = '0;

   lsu_mem_port dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .ex_valid(ex_valid), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
      .ex_addr(ex_addr), .ex_store_data(ex_store_data), .clear_in(clear_in),
      .lsu_busy(lsu_busy), .wb_valid(wb_valid), .wb_data(wb_data),
      .read_mem(read_mem), .write_mem(write_mem), .mem_addr(mem_addr),
      .mem_data_to_write(mem_data_to_write), .data_len(data_len),
      .mem_load_done(mem_load_done), .mem_ctrl_load_to_mem(mem_ctrl_load_to_mem)
   );

   always #5 clk_in = ~clk_in;

   // Controller: serves a request LAT+1 cycles, then a one-cycle registered done pulse.
   logic done_q;
   logic [31:0] rd_q;
   int cnt;
   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         done_q <= 1'b0; rd_q <= '0; cnt <= 0;
      end else if (rdy_in) begin
         done_q <= 1'b0;
         if ((read_mem || write_mem) && !done_q) begin
            if (cnt == LAT) begin
               done_q <= 1'b1; cnt <= 0; rd_q <= mem_rdata;
            end else cnt <= cnt + 1;
         end
      end
   end
   assign mem_load_done = done_q;
   assign mem_ctrl_load_to_mem = rd_q;

   always @(negedge clk_in) begin
      if (rst_in && rdy_in) begin
         checks++;
         if (read_mem && write_mem) begin
            failures++;
            $display("FAIL both_req: read_mem=%0b write_mem=%0b, required not both 1", read_mem, write_mem);
         end
         if (wb_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL wb_unexpected: wb_valid=1 wb_data=%h, required wb_valid=0", wb_data);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (wb_data !== e) begin
                  failures++;
                  $display("FAIL wb_data: got %h, required %h", wb_data, e);
               end
            end
         end
      end
   end

   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input logic push, input logic [31:0] exp_wb, input logic [2:0] exp_len);
      @(negedge clk_in);
      ex_valid = 1'b1; ex_is_store = st; ex_funct3 = f3; ex_addr = addr; ex_store_data = sdata;
      mem_rdata = rdata;
      if (push) exp_q.push_back(exp_wb);
      @(negedge clk_in);
      ex_valid = 1'b0;
      checks++;
      if (lsu_busy !== 1'b1 || data_len !== exp_len || mem_addr !== addr ||
          read_mem !== !st || write_mem !== st) begin
         failures++;
         $display("FAIL accept: busy=%b len=%0d addr=%h rd=%b wr=%b, required busy=1 len=%0d addr=%h rd=%b wr=%b",
                  lsu_busy, data_len, mem_addr, read_mem, write_mem, exp_len, addr, !st, st);
      end
   endtask

   task automatic wait_done(input logic st, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [2:0] len, input logic drain);
      int n;
      n = 0;
      while (lsu_busy === 1'b1 && n < 50) begin
         checks++;
         if (mem_addr !== addr || mem_data_to_write !== sdata || data_len !== len ||
             read_mem !== (!st && !mem_load_done) || write_mem !== (st && !mem_load_done)) begin
            failures++;
            $display("FAIL hold: addr=%h data=%h len=%0d rd=%b wr=%b done=%b, required addr=%h data=%h len=%0d",
                     mem_addr, mem_data_to_write, data_len, read_mem, write_mem, mem_load_done, addr, sdata, len);
         end
         @(negedge clk_in);
         n++;
      end
      checks++;
      if (n >= 50) begin
         failures++;
         $display("FAIL timeout: lsu_busy=%b after %0d cycles, required 0", lsu_busy, n);
      end
      checks++;
      if (read_mem !== 1'b0 || write_mem !== 1'b0) begin
         failures++;
         $display("FAIL idle_req: rd=%b wr=%b, required 0 0", read_mem, write_mem);
      end
      if (drain) begin
         repeat (2) @(negedge clk_in);
         checks++;
         if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wb_missing: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
         end
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (lsu_busy !== 0 || wb_valid !== 0 || wb_data !== 0 || read_mem !== 0 || write_mem !== 0 ||
          mem_addr !== 0 || mem_data_to_write !== 0 || data_len !== 3'd1) begin
         failures++;
         $display("FAIL reset: busy=%b wbv=%b wbd=%h rd=%b wr=%b addr=%h data=%h len=%0d, required all 0 len=1",
                  lsu_busy, wb_valid, wb_data, read_mem, write_mem, mem_addr, mem_data_to_write, data_len);
      end
      @(negedge clk_in); rst_in = 1'b1;
      // done pulses in IDLE must be ignored
      @(negedge clk_in);
      checks++;
      if (lsu_busy !== 0) begin
         failures++;
         $display("FAIL reset_release: busy=%b, required 0", lsu_busy);
      end
   endtask

   task automatic test_loads();
      issue(0, 3'b000, 32'h100, 0, 32'h0000_00F0, 1, 32'hFFFF_FFF0, 3'd1);
      wait_done(0, 32'h100, 0, 3'd1, 1);
      issue(0, 3'b101, 32'h200, 0, 32'h0000_F00D, 1, 32'h0000_F00D, 3'd2);
      wait_done(0, 32'h200, 0, 3'd2, 1);
      issue(0, 3'b001, 32'h200, 0, 32'h0000_F00D, 1, 32'hFFFF_F00D, 3'd2);
      wait_done(0, 32'h200, 0, 3'd2, 1);
      issue(0, 3'b100, 32'h204, 0, 32'h1234_5680, 1, 32'h0000_0080, 3'd1);
      wait_done(0, 32'h204, 0, 3'd1, 1);
      issue(0, 3'b001, 32'h206, 0, 32'hABCD_7FFF, 1, 32'h0000_7FFF, 3'd2);
      wait_done(0, 32'h206, 0, 3'd2, 1);
      issue(0, 3'b010, 32'h208, 0, 32'hCAFE_BABE, 1, 32'hCAFE_BABE, 3'd4);
      wait_done(0, 32'h208, 0, 3'd4, 1);
      issue(0, 3'b110, 32'h20C, 0, 32'h8000_0081, 1, 32'h8000_0081, 3'd4);
      wait_done(0, 32'h20C, 0, 3'd4, 1);
      issue(0, 3'b011, 32'h210, 0, 32'h0000_00FF, 1, 32'h0000_00FF, 3'd4);
      wait_done(0, 32'h210, 0, 3'd4, 1);
   endtask

   task automatic test_store();
      issue(1, 3'b010, 32'h300, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0, 3'd4);
      wait_done(1, 32'h300, 32'hDEAD_BEEF, 3'd4, 1);
      issue(1, 3'b001, 32'h302, 32'h0000_A5A5, 0, 0, 0, 3'd2);
      wait_done(1, 32'h302, 32'h0000_A5A5, 3'd2, 1);
   endtask

   task automatic test_back_to_back();
      issue(0, 3'b010, 32'h400, 0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 3'd4);
      wait_done(0, 32'h400, 0, 3'd4, 0);
      issue(1, 3'b000, 32'h404, 32'h0000_0077, 0, 0, 0, 3'd1);
      wait_done(1, 32'h404, 32'h0000_0077, 3'd1, 1);
   endtask

   task automatic test_clear();
      issue(0, 3'b010, 32'h500, 0, 32'h1111_2222, 0, 0, 3'd4);
      clear_in = 1'b1;
      @(negedge clk_in);
      clear_in = 1'b0;
      wait_done(0, 32'h500, 0, 3'd4, 1);
      // flush in IDLE blocks acceptance
      ex_valid = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h600; clear_in = 1'b1;
      @(negedge clk_in);
      ex_valid = 1'b0; clear_in = 1'b0;
      checks++;
      if (lsu_busy !== 1'b0 || read_mem !== 1'b0) begin
         failures++;
         $display("FAIL clear_idle: busy=%b rd=%b, required 0 0", lsu_busy, read_mem);
      end
      repeat (3) @(negedge clk_in);
   endtask

   task automatic test_rdy_hold();
      issue(0, 3'b001, 32'h700, 0, 32'h0000_8001, 1, 32'hFFFF_8001, 3'd2);
      rdy_in = 1'b0;
      repeat (3) begin
         @(negedge clk_in);
         checks++;
         if (lsu_busy !== 1'b1 || read_mem !== 1'b1 || wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL rdy_hold: busy=%b rd=%b wbv=%b, required 1 1 0", lsu_busy, read_mem, wb_valid);
         end
      end
      rdy_in = 1'b1;
      wait_done(0, 32'h700, 0, 3'd2, 1);
   endtask

   task automatic test_reset_mid();
      issue(0, 3'b000, 32'h800, 0, 32'h0000_0011, 0, 0, 3'd1);
      #2 rst_in = 1'b0;
      #1;
      checks++;
      if (read_mem !== 0 || lsu_busy !== 0 || wb_valid !== 0) begin
         failures++;
         $display("FAIL reset_mid: rd=%b busy=%b wbv=%b, required 0 0 0", read_mem, lsu_busy, wb_valid);
      end
      @(negedge clk_in); rst_in = 1'b1;
      repeat (6) @(negedge clk_in);
      checks++;
      if (lsu_busy !== 0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL reset_after: busy=%b pending=%0d, required 0 0", lsu_busy, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_store();
      test_back_to_back();
      test_clear();
      test_rdy_hold();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
